// File: rtl/ecc_pkg.sv
// Shared helpers for the SECDED encoder/decoder: Hamming position mapping,
// check-bit count and result flag encoding.
package ecc_pkg;

    localparam logic [1:0] FLAG_CLEAN = 2'd0;
    localparam logic [1:0] FLAG_CE    = 2'd1;
    localparam logic [1:0] FLAG_UE    = 2'd2;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Smallest r with 2^r >= dw + r + 1.
    function automatic int calc_r(input int dw);
        int r;
        r = 1;
        while ((1 << r) < dw + r + 1) r = r + 1;
        return r;
    endfunction

    // Data bit k sits at the k-th position >= 3 that is not a power of two.
    function automatic int hpos(input int k);
        int pos;
        int cnt;
        pos = 2;
        cnt = -1;
        while (cnt < k) begin
            pos = pos + 1;
            if (!is_pow2(pos)) cnt = cnt + 1;
        end
        return pos;
    endfunction

endpackage

// File: rtl/ecc_secded_enc.sv
// Combinational SECDED encoder: Hamming check bits plus overall even parity.
// Used by the decoder to recompute check bits; also usable on the write path.
module ecc_secded_enc
    import ecc_pkg::*;
#(
    parameter int DW = 32,
    localparam int R = calc_r(DW)
) (
    input  logic [DW-1:0] data,
    output logic [R-1:0]  check,
    output logic          par
);

    // Check bit j covers every data bit whose Hamming position has bit j set.
    always_comb begin
        check = '0;
        for (int j = 0; j < R; j++) begin
            for (int k = 0; k < DW; k++) begin
                check[j] = check[j] ^ (data[k] & (((hpos(k) >> j) & 1) == 1));
            end
        end
        par = (^data) ^ (^check);
    end

endmodule

// File: rtl/ecc_secded_dec_pipe.sv
// Two-stage pipelined SECDED decoder with valid/ready flow control and
// saturating corrected/uncorrectable event counters.
module ecc_secded_dec_pipe
    import ecc_pkg::*;
#(
    parameter int DW   = 32,
    parameter int CNTW = 16,
    localparam int R   = calc_r(DW),
    localparam int CWW = DW + R + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [CWW-1:0]  in_cw,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [DW-1:0]   out_data,
    output logic            out_ce,
    output logic            out_ue,
    output logic [R:0]      out_syn,
    input  logic            cnt_clr,
    output logic [CNTW-1:0] ce_cnt,
    output logic [CNTW-1:0] ue_cnt
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic [R-1:0]  calc_c_s;
    logic          calc_p_s;
    logic [R-1:0]  syn_s;
    logic          pm_s;
    logic          s1_vld_r;
    logic [DW-1:0] s1_data_r;
    logic [R-1:0]  s1_syn_r;
    logic          s1_pm_r;
    logic          s2_vld_r;
    logic          s1_load_s;
    logic          s2_load_s;
    logic          hs_s;
    logic [DW-1:0] flip_s;
    logic [1:0]    flag_s;
    logic [DW-1:0] corr_s;

    ecc_secded_enc #(.DW(DW)) u_enc (
        .data  (in_cw[DW-1:0]),
        .check (calc_c_s),
        .par   (calc_p_s)
    );

    // XOR over the whole codeword, rebuilt from the encoder parity:
    // ^cw = calc_p ^ ^calc_c ^ ^recv_c ^ p = calc_p ^ ^syn ^ p.
    assign syn_s = calc_c_s ^ in_cw[DW+R-1:DW];
    assign pm_s  = calc_p_s ^ (^syn_s) ^ in_cw[CWW-1];

    assign s2_load_s = !s2_vld_r | out_rdy;
    assign s1_load_s = !s1_vld_r | s2_load_s;
    assign in_rdy    = s1_load_s;
    assign out_vld   = s2_vld_r;
    assign hs_s      = s2_vld_r & out_rdy;

    // Stage 1: capture raw data with its syndrome and parity mismatch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_r  <= 1'b0;
            s1_data_r <= '0;
            s1_syn_r  <= '0;
            s1_pm_r   <= 1'b0;
        end else if (s1_load_s) begin
            s1_vld_r <= in_vld;
            if (in_vld) begin
                s1_data_r <= in_cw[DW-1:0];
                s1_syn_r  <= syn_s;
                s1_pm_r   <= pm_s;
            end
        end
    end

    // One-hot match of the syndrome against each data bit's position.
    always_comb begin
        flip_s = '0;
        for (int k = 0; k < DW; k++) begin
            flip_s[k] = (int'(s1_syn_r) == hpos(k));
        end
    end

    // Classify the stage-1 word and build the corrected data.
    always_comb begin
        flag_s = FLAG_CLEAN;
        corr_s = s1_data_r;
        if (!s1_pm_r) begin
            if (s1_syn_r != '0) begin
                flag_s = FLAG_UE;
            end else begin
                flag_s = FLAG_CLEAN;
            end
        end else if (s1_syn_r == '0 || is_pow2(int'(s1_syn_r))) begin
            flag_s = FLAG_CE;
        end else if (|flip_s) begin
            flag_s = FLAG_CE;
            corr_s = s1_data_r ^ flip_s;
        end else begin
            flag_s = FLAG_UE;
        end
    end

    // Stage 2: registered outputs, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_vld_r <= 1'b0;
            out_data <= '0;
            out_ce   <= 1'b0;
            out_ue   <= 1'b0;
            out_syn  <= '0;
        end else if (s2_load_s) begin
            s2_vld_r <= s1_vld_r;
            if (s1_vld_r) begin
                out_data <= corr_s;
                out_ce   <= (flag_s == FLAG_CE);
                out_ue   <= (flag_s == FLAG_UE);
                out_syn  <= {s1_pm_r, s1_syn_r};
            end
        end
    end

    // Saturating event counters, advanced only when a result is consumed.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            ce_cnt <= '0;
            ue_cnt <= '0;
        end else begin
            if (hs_s && out_ce && ce_cnt != CNT_MAX) ce_cnt <= ce_cnt + 1'b1;
            if (hs_s && out_ue && ue_cnt != CNT_MAX) ue_cnt <= ue_cnt + 1'b1;
        end
    end

endmodule
